ppe_arbiter_ctrl: RTL and testbench



---
 rtl/ppe_arbiter_ctrl_if.sv | 41 ++++
 rtl/ppe_arbiter_ctrl.sv | 111 +++++++++++
 tb/tb_ppe_arbiter_ctrl.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ppe_arbiter_ctrl_if.sv
// Request/grant bundle between the requesters, the arbiter and the consumer.
// The lock signal exists only when PPE_ARB_LOCK_EN is defined.
interface ppe_arbiter_ctrl_if #(
  parameter int N = 16,
  parameter int W = 4
);
  logic [N-1:0] req;
  logic         mode;
  logic         base_wr;
  logic [W-1:0] base_in;
  logic         gnt_ready;
`ifdef PPE_ARB_LOCK_EN
  logic         lock;
`endif
  logic         gnt_valid;
  logic [W-1:0] gnt_idx;
  logic [N-1:0] gnt_onehot;
  logic         busy;
  logic [W-1:0] base;
  logic [15:0]  gnt_cnt;

`ifdef PPE_ARB_LOCK_EN
  modport master (
    output req, mode, base_wr, base_in, gnt_ready, lock,
    input  gnt_valid, gnt_idx, gnt_onehot, busy, base, gnt_cnt
  );
  modport slave (
    input  req, mode, base_wr, base_in, gnt_ready, lock,
    output gnt_valid, gnt_idx, gnt_onehot, busy, base, gnt_cnt
  );
`else
  modport master (
    output req, mode, base_wr, base_in, gnt_ready,
    input  gnt_valid, gnt_idx, gnt_onehot, busy, base, gnt_cnt
  );
  modport slave (
    input  req, mode, base_wr, base_in, gnt_ready,
    output gnt_valid, gnt_idx, gnt_onehot, busy, base, gnt_cnt
  );
`endif
endinterface

// File: rtl/ppe_arbiter_ctrl.sv
// Rotating-base priority arbiter with a registered grant held under valid/ready.
// Optional grant locking (GRANT->GRANT on handshake) is enabled by PPE_ARB_LOCK_EN.
module ppe_arbiter_ctrl #(
  parameter int N = 16,
  parameter int W = 4
) (
  input logic clk,
  input logic rst,
  ppe_arbiter_ctrl_if.slave bus
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t       state_q, state_d;
  logic         gnt_valid_q, gnt_valid_d;
  logic [W-1:0] gnt_idx_q, gnt_idx_d;
  logic [N-1:0] gnt_onehot_q, gnt_onehot_d;
  logic         busy_q, busy_d;
  logic [W-1:0] base_q, base_d;
  logic [15:0]  gnt_cnt_q, gnt_cnt_d;

  logic [W-1:0] scan_idx;
  logic [W-1:0] winner;
  logic         handshake;
  logic         hold_lock;

  // Scan downward from base+N-1 to base so the last hit is the first set bit at or above base;
  // W-bit addition wraps modulo N because N is a power of two.
  always_comb begin
    scan_idx = '0;
    winner   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      scan_idx = base_q + W'(i);
      if (bus.req[scan_idx]) winner = scan_idx;
    end
  end

  assign handshake = (state_q == GRANT) && gnt_valid_q && bus.gnt_ready;

`ifdef PPE_ARB_LOCK_EN
  assign hold_lock = bus.lock && bus.req[gnt_idx_q];
`else
  assign hold_lock = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    gnt_valid_d  = gnt_valid_q;
    gnt_idx_d    = gnt_idx_q;
    gnt_onehot_d = gnt_onehot_q;
    busy_d       = busy_q;
    base_d       = base_q;
    gnt_cnt_d    = gnt_cnt_q;

    case (state_q)
      IDLE: begin
        if (|bus.req) begin
          state_d      = GRANT;
          gnt_valid_d  = 1'b1;
          gnt_idx_d    = winner;
          gnt_onehot_d = {{(N-1){1'b0}}, 1'b1} << winner;
          busy_d       = 1'b1;
        end
      end
      GRANT: begin
        if (handshake) begin
          if (gnt_cnt_q != 16'hFFFF) gnt_cnt_d = gnt_cnt_q + 16'd1;
          if (!hold_lock) begin
            state_d      = IDLE;
            gnt_valid_d  = 1'b0;
            gnt_onehot_d = '0;
            busy_d       = 1'b0;
            if (!bus.mode) base_d = gnt_idx_q + W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // An explicit base load wins over a same-cycle round-robin advance.
    if (bus.base_wr) base_d = bus.base_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      gnt_valid_q  <= 1'b0;
      gnt_idx_q    <= '0;
      gnt_onehot_q <= '0;
      busy_q       <= 1'b0;
      base_q       <= '0;
      gnt_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      gnt_valid_q  <= gnt_valid_d;
      gnt_idx_q    <= gnt_idx_d;
      gnt_onehot_q <= gnt_onehot_d;
      busy_q       <= busy_d;
      base_q       <= base_d;
      gnt_cnt_q    <= gnt_cnt_d;
    end
  end

  assign bus.gnt_valid  = gnt_valid_q;
  assign bus.gnt_idx    = gnt_idx_q;
  assign bus.gnt_onehot = gnt_onehot_q;
  assign bus.busy       = busy_q;
  assign bus.base       = base_q;
  assign bus.gnt_cnt    = gnt_cnt_q;

endmodule

// File: tb/tb_ppe_arbiter_ctrl.sv
// Self-checking bench for ppe_arbiter_ctrl: directed scenarios plus random traffic
// compared against a behavioural arbiter model; lock scenarios run when PPE_ARB_LOCK_EN is defined.
module tb_ppe_arbiter_ctrl;

  localparam int N = 16;
  localparam int W = 4;

  logic clk;
  logic rst;
  logic lockIn;

  int total;
  int bad;

  // Behavioural model state
  bit mGranted;
  int mIdx;
  int mBase;
  int mCnt;

  int grants[$];

  ppe_arbiter_ctrl_if #(.N(N), .W(W)) bus ();

  ppe_arbiter_ctrl #(.N(N), .W(W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

`ifdef PPE_ARB_LOCK_EN
  assign bus.lock = lockIn;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Winner is the first requester found walking upward from base, wrapping modulo N.
  function automatic int pickWinner(input logic [N-1:0] r, input int b);
    for (int k = 0; k < N; k++) begin
      if (r[(b + k) % N]) return (b + k) % N;
    end
    return -1;
  endfunction

  function automatic void modelReset();
    mGranted = 1'b0;
    mIdx     = 0;
    mBase    = 0;
    mCnt     = 0;
  endfunction

  // Advances the model by one clock edge using the inputs present at that edge.
  function automatic void modelStep();
    int nextBase;
    bit keep;
    nextBase = mBase;
    if (!mGranted) begin
      if (bus.req != '0) begin
        mIdx     = pickWinner(bus.req, mBase);
        mGranted = 1'b1;
      end
    end else if (bus.gnt_ready) begin
      if (mCnt < 65535) mCnt++;
      keep = 1'b0;
`ifdef PPE_ARB_LOCK_EN
      keep = lockIn && bus.req[mIdx];
`endif
      if (!keep) begin
        mGranted = 1'b0;
        if (!bus.mode) nextBase = (mIdx + 1) % N;
      end
    end
    if (bus.base_wr) nextBase = int'(bus.base_in);
    mBase = nextBase;
  endfunction

  task automatic checkOutput(input string tag);
    logic [N-1:0] expOnehot;
    expOnehot = mGranted ? (N'(1) << mIdx) : '0;
    total++;
    assert (bus.gnt_valid === mGranted)
      else begin bad++; $error("[TB] FAIL %s gnt_valid got %0b exp %0b", tag, bus.gnt_valid, mGranted); end
    total++;
    assert (bus.busy === mGranted)
      else begin bad++; $error("[TB] FAIL %s busy got %0b exp %0b", tag, bus.busy, mGranted); end
    total++;
    assert (bus.gnt_idx === W'(mIdx))
      else begin bad++; $error("[TB] FAIL %s gnt_idx got %0d exp %0d", tag, bus.gnt_idx, mIdx); end
    total++;
    assert (bus.gnt_onehot === expOnehot)
      else begin bad++; $error("[TB] FAIL %s gnt_onehot got %h exp %h", tag, bus.gnt_onehot, expOnehot); end
    total++;
    assert (bus.base === W'(mBase))
      else begin bad++; $error("[TB] FAIL %s base got %0d exp %0d", tag, bus.base, mBase); end
    total++;
    assert (bus.gnt_cnt === 16'(mCnt))
      else begin bad++; $error("[TB] FAIL %s gnt_cnt got %0d exp %0d", tag, bus.gnt_cnt, mCnt); end
  endtask

  // Drives one cycle of inputs, clocks it, updates the model and checks outputs #1 after the edge.
  task automatic applyStimulus(input logic [N-1:0] r, input logic m, input logic bw,
                               input logic [W-1:0] bi, input logic rdy, input string tag);
    bus.req       = r;
    bus.mode      = m;
    bus.base_wr   = bw;
    bus.base_in   = bi;
    bus.gnt_ready = rdy;
    @(posedge clk);
    modelStep();
    #1;
    checkOutput(tag);
  endtask

  // Reset is asserted between edges to exercise its asynchronous path.
  task automatic asyncReset(input string tag);
    rst = 1'b1;
    #1;
    modelReset();
    checkOutput(tag);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic checkEq(input string tag, input int got, input int exp);
    total++;
    assert (got === exp)
      else begin bad++; $error("[TB] FAIL %s got %0d exp %0d", tag, got, exp); end
  endtask

  initial begin
    total = 0;
    bad = 0;
    lockIn = 1'b0;
    rst = 1'b1;
    bus.req = '0;
    bus.mode = 1'b0;
    bus.base_wr = 1'b0;
    bus.base_in = '0;
    bus.gnt_ready = 1'b0;
    modelReset();

    // Power-on reset
    repeat (2) @(posedge clk);
    #1;
    checkOutput("por");
    rst = 1'b0;

    // Round-robin over 0x0421: expect grants 0,5,10,0,5
    grants = {};
    for (int c = 0; c < 20 && grants.size() < 5; c++) begin
      applyStimulus(16'h0421, 1'b0, 1'b0, '0, 1'b1, "rr");
      if (bus.gnt_valid) grants.push_back(int'(bus.gnt_idx));
    end
    checkEq("rr_count", grants.size(), 5);
    if (grants.size() == 5) begin
      checkEq("rr_g0", grants[0], 0);
      checkEq("rr_g1", grants[1], 5);
      checkEq("rr_g2", grants[2], 10);
      checkEq("rr_g3", grants[3], 0);
      checkEq("rr_g4", grants[4], 5);
    end
    applyStimulus('0, 1'b0, 1'b0, '0, 1'b1, "rr_drain");
    checkEq("rr_base", int'(bus.base), 6);

    // Wrap: base 11 with req 0x0009 -> grant 0 then 3; base_wr=7 during the idx-3 handshake
    applyStimulus('0, 1'b0, 1'b1, 4'd11, 1'b1, "wrap_load");
    applyStimulus(16'h0009, 1'b0, 1'b0, '0, 1'b0, "wrap_g0");
    checkEq("wrap_idx0", int'(bus.gnt_idx), 0);
    applyStimulus(16'h0009, 1'b0, 1'b0, '0, 1'b1, "wrap_hs0");
    applyStimulus(16'h0009, 1'b0, 1'b0, '0, 1'b0, "wrap_g3");
    checkEq("wrap_idx3", int'(bus.gnt_idx), 3);
    applyStimulus('0, 1'b0, 1'b1, 4'd7, 1'b1, "wrap_hs3");
    checkEq("wrap_base7", int'(bus.base), 7);

    // Fixed mode from base 4 with req 0x8011, then drop req[4]
    applyStimulus('0, 1'b1, 1'b1, 4'd4, 1'b1, "fix_load");
    for (int c = 0; c < 6; c++) applyStimulus(16'h8011, 1'b1, 1'b0, '0, 1'b1, "fix");
    checkEq("fix_base", int'(bus.base), 4);
    applyStimulus(16'h8001, 1'b1, 1'b0, '0, 1'b0, "fix_drop");
    checkEq("fix_idx15", int'(bus.gnt_idx), 15);
    applyStimulus('0, 1'b1, 1'b0, '0, 1'b1, "fix_hs");

    // Backpressure: grant to 1 stays frozen while req toggles and ready is low
    applyStimulus('0, 1'b0, 1'b1, 4'd0, 1'b0, "bp_load");
    applyStimulus(16'h0002, 1'b0, 1'b0, '0, 1'b0, "bp_g");
    for (int c = 0; c < 6; c++)
      applyStimulus((c % 2 == 0) ? 16'h0000 : 16'h0002, 1'b0, 1'b0, '0, 1'b0, "bp_hold");
    checkEq("bp_onehot", int'(bus.gnt_onehot), 32'h0002);
    applyStimulus('0, 1'b0, 1'b0, '0, 1'b1, "bp_accept");
    checkEq("bp_valid", int'(bus.gnt_valid), 0);

    // Reset in the middle of a grant at index 5
    applyStimulus('0, 1'b1, 1'b1, 4'd5, 1'b0, "mr_load");
    applyStimulus(16'h0020, 1'b1, 1'b0, '0, 1'b0, "mr_g");
    checkEq("mr_idx5", int'(bus.gnt_idx), 5);
    asyncReset("mr_rst");
    for (int c = 0; c < 10; c++) applyStimulus('0, 1'b0, 1'b0, '0, 1'b1, "mr_quiet");

`ifdef PPE_ARB_LOCK_EN
    // Lock keeps requester 1 granted on consecutive cycles without a bubble
    lockIn = 1'b1;
    applyStimulus(16'h0006, 1'b0, 1'b0, '0, 1'b1, "lk_g");
    for (int c = 0; c < 5; c++) begin
      applyStimulus(16'h0006, 1'b0, 1'b0, '0, 1'b1, "lk_hold");
      checkEq("lk_valid", int'(bus.gnt_valid), 1);
    end
    lockIn = 1'b0;
    applyStimulus(16'h0006, 1'b0, 1'b0, '0, 1'b1, "lk_release");
    applyStimulus(16'h0006, 1'b0, 1'b0, '0, 1'b1, "lk_g2");
    checkEq("lk_idx2", int'(bus.gnt_idx), 2);
    applyStimulus('0, 1'b0, 1'b0, '0, 1'b1, "lk_drain");
    // Drive the counter to saturation using locked back-to-back grants
    lockIn = 1'b1;
    bus.req = 16'h0002;
    bus.gnt_ready = 1'b1;
    for (int c = 0; c < 65545; c++) begin
      @(posedge clk);
      modelStep();
    end
    #1;
    checkEq("lk_sat", int'(bus.gnt_cnt), 65535);
    checkOutput("lk_sat_all");
    lockIn = 1'b0;
    applyStimulus('0, 1'b0, 1'b0, '0, 1'b1, "lk_end");
`endif

    // Random traffic against the model
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 59) == 0) begin
        asyncReset("rnd_rst");
      end else begin
`ifdef PPE_ARB_LOCK_EN
        lockIn = $urandom_range(0, 1) == 1;
`endif
        applyStimulus(N'($urandom & $urandom), $urandom_range(0, 1) == 1,
                      $urandom_range(0, 7) == 0, W'($urandom_range(0, N - 1)),
                      $urandom_range(0, 3) != 0, "rnd");
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
